// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, microstep encoding and control-word layout
// Purpose: constants shared by the control sequencer and its microcode table.
// Ports: none (package).
package cpu_pkg;

  // Microsteps: T0..T1 fetch, T2..T4 execute.
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  // Opcodes carried in ir[7:4]; 9..D are unassigned and behave as NOP.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control-word bit positions.
  localparam int CW_PC_ENABLE   = 0;
  localparam int CW_PC_INC      = 1;
  localparam int CW_PC_WRITE    = 2;
  localparam int CW_MAR_WRITE   = 3;
  localparam int CW_RAM_ENABLE  = 4;
  localparam int CW_RAM_WRITE   = 5;
  localparam int CW_IR_WRITE    = 6;
  localparam int CW_IR_ENABLE   = 7;
  localparam int CW_A_ENABLE    = 8;
  localparam int CW_A_WRITE     = 9;
  localparam int CW_B_WRITE     = 10;
  localparam int CW_ALU_ENABLE  = 11;
  localparam int CW_ALU_SUB     = 12;
  localparam int CW_FLAGS_WRITE = 13;
  localparam int CW_OUT_WRITE   = 14;
  localparam int CW_WIDTH       = 15;

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational microcode table
// Purpose: maps (step, opcode, flags) to a control word and a last-step flag.
// Ports:
//   step       in  current microstep
//   opcode     in  ir[7:4]
//   carry_flag in  registered ALU carry (for JC)
//   zero_flag  in  registered ALU zero (for JZ)
//   word       out control word, bit layout from cpu_pkg
//   last       out this step is the opcode's final active step
module control_decode
  import cpu_pkg::*;
(
  input  step_t                 step,
  input  logic [3:0]            opcode,
  input  logic                  carry_flag,
  input  logic                  zero_flag,
  output logic [CW_WIDTH-1:0]   word,
  output logic                  last
);

  always_comb begin
    word = '0;
    last = 1'b0;
    case (step)
      T0: begin
        word[CW_PC_ENABLE] = 1'b1;
        word[CW_MAR_WRITE] = 1'b1;
      end
      T1: begin
        word[CW_RAM_ENABLE] = 1'b1;
        word[CW_IR_WRITE]   = 1'b1;
        word[CW_PC_INC]     = 1'b1;
      end
      default: begin
        case (opcode)
          OP_LDA: begin
            if (step == T2) begin
              word[CW_IR_ENABLE] = 1'b1;
              word[CW_MAR_WRITE] = 1'b1;
            end else if (step == T3) begin
              word[CW_RAM_ENABLE] = 1'b1;
              word[CW_A_WRITE]    = 1'b1;
            end
            last = (step == T3);
          end
          OP_ADD, OP_SUB: begin
            if (step == T2) begin
              word[CW_IR_ENABLE] = 1'b1;
              word[CW_MAR_WRITE] = 1'b1;
            end else if (step == T3) begin
              word[CW_RAM_ENABLE] = 1'b1;
              word[CW_B_WRITE]    = 1'b1;
            end else if (step == T4) begin
              word[CW_ALU_ENABLE]  = 1'b1;
              word[CW_A_WRITE]     = 1'b1;
              word[CW_FLAGS_WRITE] = 1'b1;
              word[CW_ALU_SUB]     = (opcode == OP_SUB);
            end
            last = (step == T4);
          end
          OP_STA: begin
            if (step == T2) begin
              word[CW_IR_ENABLE] = 1'b1;
              word[CW_MAR_WRITE] = 1'b1;
            end else if (step == T3) begin
              word[CW_A_ENABLE]  = 1'b1;
              word[CW_RAM_WRITE] = 1'b1;
            end
            last = (step == T3);
          end
          OP_LDI: begin
            if (step == T2) begin
              word[CW_IR_ENABLE] = 1'b1;
              word[CW_A_WRITE]   = 1'b1;
            end
            last = (step == T2);
          end
          OP_JMP, OP_JC, OP_JZ: begin
            // Conditional jumps read the flags as they stand in T2; a
            // flags_write landing at the end of this cycle is too late.
            if (step == T2 &&
                (opcode == OP_JMP ||
                 (opcode == OP_JC && carry_flag) ||
                 (opcode == OP_JZ && zero_flag))) begin
              word[CW_IR_ENABLE] = 1'b1;
              word[CW_PC_WRITE]  = 1'b1;
            end
            last = (step == T2);
          end
          OP_OUT: begin
            if (step == T2) begin
              word[CW_A_ENABLE]  = 1'b1;
              word[CW_OUT_WRITE] = 1'b1;
            end
            last = (step == T2);
          end
          default: begin
            // NOP, HLT and the unassigned opcodes: one empty execute step.
            last = (step == T2);
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microstep counter, halt latch and control strobes
// Purpose: steps T0..T4, decodes ir[7:4] into per-cycle bus strobes, halts on HLT.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ir                    instruction register ([7:4] opcode)
//   carry_flag, zero_flag registered ALU flags
//   pc_*..out_write       control strobes, valid for the whole cycle
//   halted                sticky halt indicator
//   step                  current microstep 0..4
module control_sequencer
  import cpu_pkg::*;
#(
  parameter bit EARLY_END = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       pc_enable,
  output logic       pc_inc,
  output logic       pc_write,
  output logic       mar_write,
  output logic       ram_enable,
  output logic       ram_write,
  output logic       ir_write,
  output logic       ir_enable,
  output logic       a_enable,
  output logic       a_write,
  output logic       b_write,
  output logic       alu_enable,
  output logic       alu_sub,
  output logic       flags_write,
  output logic       out_write,
  output logic       halted,
  output logic [2:0] step
);

  step_t                step_q, step_d;
  logic                 halted_q, halted_d;
  logic [CW_WIDTH-1:0]  raw_word, word;
  logic                 last;

  control_decode u_decode (
    .step       (step_q),
    .opcode     (ir[7:4]),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .word       (raw_word),
    .last       (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d = T0;
    end else if (step_q == T2 && ir[7:4] == OP_HLT) begin
      halted_d = 1'b1;
      step_d   = T0;
    end else if (step_q == T4 || (EARLY_END && last)) begin
      step_d = T0;
    end else begin
      step_d = step_t'(step_q + 3'd1);
    end
  end

  // Reset is applied combinationally so no strobe leaks out while it is held.
  assign word = (reset || halted_q) ? '0 : raw_word;

  assign pc_enable   = word[CW_PC_ENABLE];
  assign pc_inc      = word[CW_PC_INC];
  assign pc_write    = word[CW_PC_WRITE];
  assign mar_write   = word[CW_MAR_WRITE];
  assign ram_enable  = word[CW_RAM_ENABLE];
  assign ram_write   = word[CW_RAM_WRITE];
  assign ir_write    = word[CW_IR_WRITE];
  assign ir_enable   = word[CW_IR_ENABLE];
  assign a_enable    = word[CW_A_ENABLE];
  assign a_write     = word[CW_A_WRITE];
  assign b_write     = word[CW_B_WRITE];
  assign alu_enable  = word[CW_ALU_ENABLE];
  assign alu_sub     = word[CW_ALU_SUB];
  assign flags_write = word[CW_FLAGS_WRITE];
  assign out_write   = word[CW_OUT_WRITE];
  assign halted      = halted_q;
  assign step        = step_q;

endmodule
